// File: rtl/hdb3_pkg.sv
// hdb3_pkg: shared HDB3 line-code definitions used by the encoder and decoder.
//   sym_code_e   : 2-bit symbol codes carried in encoding_data[1:0]
//   HDB3_RUN     : substitution length, also the decoder delay depth
//   POL_BIT / CODE_MSB / CODE_LSB : symbol field positions
package hdb3_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        ONE  = 2'b01,
        V    = 2'b10,
        B    = 2'b11
    } sym_code_e;

    localparam int unsigned HDB3_RUN = 4;

    localparam int unsigned POL_BIT  = 2;
    localparam int unsigned CODE_MSB = 1;
    localparam int unsigned CODE_LSB = 0;

    // Any nonzero code (ONE, V or B) is a line pulse.
    function automatic logic sym_is_pulse(input logic [2:0] sym);
        return |sym[CODE_MSB:CODE_LSB];
    endfunction

endpackage

// File: rtl/hdb3_violation_detect.sv
// hdb3_violation_detect: tracks the polarity of the last line pulse and flags
// bipolar violations (a pulse with the same polarity as the previous pulse).
//   clk, rst   : clock, synchronous active-high reset
//   accept     : a symbol is being consumed this cycle
//   pulse, pol : pulse presence and polarity of the current symbol
//   violation  : combinational, current symbol is a V
//   v_error    : (HDB3_DEC_ERR_CHECK_EN only) current V repeats the polarity
//                of the previous V
module hdb3_violation_detect
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic pulse,
    input  logic pol,
`ifdef HDB3_DEC_ERR_CHECK_EN
    output logic v_error,
`endif
    output logic violation
);

    logic last_pol;

    assign violation = pulse && (pol == last_pol);

    // Reset to 0 so the first mark from a freshly reset encoder (positive)
    // is not taken as a violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pol <= 1'b0;
        end else if (accept && pulse) begin
            last_pol <= pol;
        end
    end

`ifdef HDB3_DEC_ERR_CHECK_EN
    logic last_v_pol;
    logic v_seen;

    // The first V after reset has no predecessor and cannot flag.
    assign v_error = violation && v_seen && (pol == last_v_pol);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_v_pol <= 1'b0;
            v_seen     <= 1'b0;
        end else if (accept && violation) begin
            last_v_pol <= pol;
            v_seen     <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/hdb3_decoder.sv
// hdb3_decoder: receive-side HDB3 decoder. Removes 000V/B00V substitutions
// through a 4-deep delay line that is cleared whenever a violation arrives.
//   clk, rst                  : clock, synchronous active-high reset
//   encoding_data[2:0]        : line symbol, bit 2 polarity, bits 1:0 code
//   encoding_data_instruction : symbol valid
//   decoded_data              : recovered bit (4-symbol latency)
//   decoded_data_instruction  : one-cycle strobe per recovered bit
//   code_error                : one-cycle line-code error strobe; only active
//                               when HDB3_DEC_ERR_CHECK_EN is defined
module hdb3_decoder
    import hdb3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] encoding_data,
    input  logic       encoding_data_instruction,
    output logic       decoded_data,
    output logic       decoded_data_instruction,
    output logic       code_error
);

    logic                accept;
    logic                pulse;
    logic                pol;
    logic                violation;
    logic [HDB3_RUN-1:0] line;
    logic [2:0]          fill;
    logic                full;

    assign accept = encoding_data_instruction;
    assign pulse  = sym_is_pulse(encoding_data);
    assign pol    = encoding_data[POL_BIT];
    assign full   = (fill == 3'(HDB3_RUN));

`ifdef HDB3_DEC_ERR_CHECK_EN
    logic v_error;
`endif

    hdb3_violation_detect u_vdet (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .pulse     (pulse),
        .pol       (pol),
`ifdef HDB3_DEC_ERR_CHECK_EN
        .v_error   (v_error),
`endif
        .violation (violation)
    );

    // A violation zeroes the whole line: in both 000V and B00V the V and the
    // three symbols before it decode to zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            line                     <= '0;
            fill                     <= '0;
            decoded_data             <= 1'b0;
            decoded_data_instruction <= 1'b0;
        end else if (accept) begin
            decoded_data             <= line[HDB3_RUN-1];
            decoded_data_instruction <= full;
            if (violation) begin
                line <= '0;
            end else begin
                line <= {line[HDB3_RUN-2:0], pulse};
            end
            if (!full) begin
                fill <= fill + 3'd1;
            end
        end else begin
            decoded_data_instruction <= 1'b0;
        end
    end

`ifdef HDB3_DEC_ERR_CHECK_EN
    logic [1:0] zero_run;

    // zero_run counts preceding zeros (saturating at 3); a zero arriving with
    // zero_run==3 is the 4th or later in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_run   <= '0;
            code_error <= 1'b0;
        end else if (accept) begin
            code_error <= (!pulse && (zero_run == 2'd3)) || v_error;
            if (pulse) begin
                zero_run <= '0;
            end else if (zero_run != 2'd3) begin
                zero_run <= zero_run + 2'd1;
            end
        end else begin
            code_error <= 1'b0;
        end
    end
`else
    assign code_error = 1'b0;
`endif

endmodule

// File: doc/hdb3_decoder.md
# hdb3_decoder

Receive-side HDB3 decoder and the counterpart of the encoder's polarity-loading stage. It consumes the signed 3-bit symbol stream produced by the transmit chain, tracks pulse polarity, detects bipolar violations (V), removes the 000V/B00V substitutions, and emits the recovered binary data with a valid strobe. It sits at the head of the receive path, between the line interface and downstream framing logic.

## Interface
- No parameters. Delay depth is fixed at 4 symbols by the HDB3 substitution length.
- clk  in  1  single system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- encoding_data  in  3  line symbol:
  - bit 2 = polarity (1 = positive);
  - bits 1:0 = nonzero for a pulse, 00 for no pulse.
  - The decoder ignores the V/B distinction carried in bits 1:0 and uses only pulse presence and polarity.
- encoding_data_instruction  in  1  symbol valid; a symbol is accepted on every clk edge where this is high.
- decoded_data  out  1  recovered bit.
- decoded_data_instruction  out  1  decoded_data valid, one-cycle strobe per emitted bit.
- code_error  out  1  one-cycle line-code error strobe (see Configuration).

## Operation
- Derived per accepted symbol:
  - pulse = |encoding_data[1:0];
  - pol = encoding_data[2].
- last_pol register holds the polarity of the most recent pulse. It resets to 0, matching the encoder's reset polarity, so the first mark arrives positive.
- Violation: an accepted symbol with pulse=1 and pol==last_pol. Every pulse, including a V, updates last_pol.
- Delay line line[3:0] holds decoded bits, with line[0] the newest. On each accepted symbol:
  - decoded_data <= line[3];
  - no violation: line <= {line[2:0], pulse};
  - violation: line <= 4'b0000. The V itself and the three preceding symbols are zeros in both the 000V and B00V forms.
- fill counter, 0..4, saturating; it increments per accepted symbol. decoded_data_instruction <= 1 only when a symbol is accepted with fill==4.
- No accepted symbol: the line, last_pol, fill and decoded_data all hold, and decoded_data_instruction <= 0.

## Timing
- Reset (rst=1 at a clk edge) clears the following, overriding any simultaneous valid input:
  - decoded_data=0, decoded_data_instruction=0, code_error=0;
  - line=0, last_pol=0, fill=0, error state cleared.
- Latency: the bit for symbol k is registered on the edge that accepts symbol k+4. It is visible in the following cycle alongside decoded_data_instruction=1.
- Throughput: one symbol per clock. Gaps in encoding_data_instruction stall the pipeline without losing data.
- Reset mid-stream discards up to 4 buffered bits. The next accepted symbol restarts fill from 0.
- Zero symbols never update last_pol.
- A violation arriving while fill<4 still clears the whole line.

## Configuration
- HDB3_DEC_ERR_CHECK_EN defined: code_error is registered high for one cycle after accepting a symbol that completes either error condition:
  - a 4th consecutive zero symbol (illegal in HDB3);
  - a violation with the same polarity as the previous violation (V must alternate).
- Both error conditions are tracked by a zero-run counter (0..3, saturating) and a last_v_pol/v_seen pair, all reset by rst.
- The first violation after reset never flags.
- Decoding is unaffected by the error checks.
- Macro undefined: code_error is tied to 0 and the checker logic is absent.

## Structure
- Shared package hdb3_pkg:
  - symbol code constants ZERO=2'b00, ONE=2'b01, V=2'b10, B=2'b11, shared with the encoder;
  - HDB3_RUN=4, the substitution length and delay depth;
  - the symbol field positions (polarity bit 2, code bits 1:0).
- One sub-module, hdb3_violation_detect: holds last_pol, outputs the violation flag, and (under the macro) does the V-alternation check.
- The top level owns the delay line, fill counter, output registers and zero-run counter.

## Test plan
- Plain marks after reset: symbols +,-,0,+, then -,0,+,- to flush → decoded 1,1,0,1 with strobes; code_error=0.
- 000V: +,0,0,0,+ (V), then 4 flush symbols -,+,-,+ → decoded 1,0,0,0,0.
- B00V: +,-,+(B),0,0,+(V), then 4 flush symbols -,+,-,+ → decoded 1,1,0,0,0,0.
- Valid gaps: the 000V case with encoding_data_instruction low for 3 cycles between every symbol → identical bit sequence; no strobes during gaps.
- Mid-stream reset: after 3 accepted symbols assert rst for 1 cycle with valid high → all outputs 0. Next +,-,+,-,+ → first strobe on the 5th accept, decoded 1; no false violation.
- Error check: 0,0,0,0 → code_error=1 exactly one cycle with HDB3_DEC_ERR_CHECK_EN, stays 0 without it. Two same-polarity Vs (+,0,0,0,+,-,+,0,0,+) → code_error on the second V only with the macro.
